rgb_gamma_lut: RTL and testbench

Per-channel 8-bit lookup-table stage for 4-pixel-per-clock RGB888 AXI-Stream video, placed directly downstream of the white-balance stage in the ISP chain. It applies three independently programmable 256-entry curves (R, G, B) to every pixel. Curve tables are double-buffered, so software can reload them mid-frame; the new curves take effect only on a frame boundary (`tuser`). A two-stage pipeline honours downstream backpressure, and a bypass mode passes data unchanged until the first table swap.

---
 rtl/rgb_gamma_lut.sv | 154 +++++++++++++++
 tb/tb_rgb_gamma_lut.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_gamma_lut.sv
`default_nettype none
// ============================================================================
// rgb_gamma_lut : per-channel 8-bit double-buffered LUT, 4 px/clk RGB888 stream
// Revision 1.0 : initial release
// ============================================================================
module rgb_gamma_lut #(
  parameter int PIX_PER_CLK = 4
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic [24*PIX_PER_CLK-1:0] I_tdata,
  input  logic                      I_tvalid,
  input  logic                      I_tuser,
  input  logic                      I_tlast,
  output logic                      I_tready,
  output logic [24*PIX_PER_CLK-1:0] O_tdata,
  output logic                      O_tvalid,
  output logic                      O_tuser,
  output logic                      O_tlast,
  input  logic                      O_tready,
  input  logic                      cfg_we,
  input  logic [9:0]                cfg_addr,
  input  logic [7:0]                cfg_wdata,
  input  logic                      cfg_swap,
  output logic                      O_swap_pending,
  output logic                      O_bypass,
  output logic                      O_cfg_err
);

  localparam int DW = 24 * PIX_PER_CLK;

  logic          adv, accept, swap_apply, wr_ok, wr_r, wr_g, wr_b;
  logic          act_bank_q, act_bank_d, bypass_q, bypass_d;
  logic          pending_q, pending_d, err_q, err_d;
  logic          s1_valid_q, s1_valid_d, s1_user_q, s1_user_d, s1_last_q, s1_last_d;
  logic          s1_bank_q, s1_bank_d, s1_bypass_q, s1_bypass_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s2_valid_q, s2_valid_d, s2_user_q, s2_user_d, s2_last_q, s2_last_d;
  logic [DW-1:0] s2_data;

  always_comb begin
    adv        = O_tready | ~s2_valid_q;
    accept     = I_tvalid & adv;
    // A swap requested in this very cycle only becomes eligible from the next frame
    swap_apply = accept & I_tuser & pending_q;
    wr_ok      = cfg_we & ~pending_q & ~cfg_swap;
    wr_r       = wr_ok & (cfg_addr[9:8] == 2'd2 || cfg_addr[9:8] == 2'd3);
    wr_g       = wr_ok & (cfg_addr[9:8] == 2'd1 || cfg_addr[9:8] == 2'd3);
    wr_b       = wr_ok & (cfg_addr[9:8] == 2'd0 || cfg_addr[9:8] == 2'd3);

    act_bank_d = act_bank_q ^ swap_apply;
    bypass_d   = bypass_q & ~swap_apply;
    pending_d  = swap_apply ? 1'b0 : (pending_q | cfg_swap);
    err_d      = err_q | (cfg_we & ~wr_ok);

    s1_valid_d  = s1_valid_q;
    s1_user_d   = s1_user_q;
    s1_last_d   = s1_last_q;
    s1_bank_d   = s1_bank_q;
    s1_bypass_d = s1_bypass_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_user_d   = s2_user_q;
    s2_last_d   = s2_last_q;
    if (adv) begin
      s1_valid_d  = accept;
      s1_user_d   = accept & I_tuser;
      s1_last_d   = accept & I_tlast;
      s1_bank_d   = act_bank_d;
      s1_bypass_d = bypass_d;
      s1_data_d   = I_tdata;
      s2_valid_d  = s1_valid_q;
      s2_user_d   = s1_user_q;
      s2_last_d   = s1_last_q;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      act_bank_q  <= 1'b0;
      bypass_q    <= 1'b1;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_user_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_bank_q   <= 1'b0;
      s1_bypass_q <= 1'b1;
      s2_valid_q  <= 1'b0;
      s2_user_q   <= 1'b0;
      s2_last_q   <= 1'b0;
    end else begin
      act_bank_q  <= act_bank_d;
      bypass_q    <= bypass_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      s1_valid_q  <= s1_valid_d;
      s1_user_q   <= s1_user_d;
      s1_last_q   <= s1_last_d;
      s1_bank_q   <= s1_bank_d;
      s1_bypass_q <= s1_bypass_d;
      s2_valid_q  <= s2_valid_d;
      s2_user_q   <= s2_user_d;
      s2_last_q   <= s2_last_d;
    end
  end

  always_ff @(posedge I_clk) begin
    s1_data_q <= s1_data_d;
  end

  // Each lane owns a private copy of all six tables; writes are broadcast
  genvar k;
  for (k = 0; k < PIX_PER_CLK; k++) begin : g_lane
    logic [7:0]  tbl_r [512];
    logic [7:0]  tbl_g [512];
    logic [7:0]  tbl_b [512];
    logic [23:0] pix_in, lut_d, lut_q;

    assign pix_in = s1_data_q[24*k +: 24];

    always_ff @(posedge I_clk) begin
      if (wr_r) tbl_r[{~act_bank_q, cfg_addr[7:0]}] <= cfg_wdata;
      if (wr_g) tbl_g[{~act_bank_q, cfg_addr[7:0]}] <= cfg_wdata;
      if (wr_b) tbl_b[{~act_bank_q, cfg_addr[7:0]}] <= cfg_wdata;
    end

    always_comb begin
      lut_d = pix_in;
      if (!s1_bypass_q) begin
        lut_d = {tbl_r[{s1_bank_q, pix_in[23:16]}],
                 tbl_g[{s1_bank_q, pix_in[15:8]}],
                 tbl_b[{s1_bank_q, pix_in[7:0]}]};
      end
    end

    always_ff @(posedge I_clk) begin
      if (adv) lut_q <= lut_d;
    end

    assign s2_data[24*k +: 24] = lut_q;
  end

  assign I_tready       = adv;
  assign O_tvalid       = s2_valid_q;
  assign O_tdata        = s2_valid_q ? s2_data : '0;
  assign O_tuser        = s2_valid_q & s2_user_q;
  assign O_tlast        = s2_valid_q & s2_last_q;
  assign O_swap_pending = pending_q;
  assign O_bypass       = bypass_q;
  assign O_cfg_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_gamma_lut.sv
`default_nettype none
// ============================================================================
// tb_rgb_gamma_lut : randomized self-checking bench with a table-level model
// Revision 1.0 : initial release
// ============================================================================
module tb_rgb_gamma_lut;

  logic        I_clk = 1'b0;
  logic        I_rst, I_tvalid, I_tuser, I_tlast, I_tready;
  logic [95:0] I_tdata, O_tdata;
  logic        O_tvalid, O_tuser, O_tlast, O_tready;
  logic        cfg_we, cfg_swap, O_swap_pending, O_bypass, O_cfg_err;
  logic [9:0]  cfg_addr;
  logic [7:0]  cfg_wdata;

  always #5 I_clk = ~I_clk;

  rgb_gamma_lut #(.PIX_PER_CLK(4)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_tdata(I_tdata), .I_tvalid(I_tvalid), .I_tuser(I_tuser), .I_tlast(I_tlast),
    .I_tready(I_tready),
    .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tuser(O_tuser), .O_tlast(O_tlast),
    .O_tready(O_tready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_swap(cfg_swap),
    .O_swap_pending(O_swap_pending), .O_bypass(O_bypass), .O_cfg_err(O_cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: tables indexed [bank][channel 0=B,1=G,2=R][entry]
  typedef struct packed {
    logic        v;
    logic [95:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic [7:0] m_tbl [2][3][256];
  bit    m_act, m_pend, m_byp, m_err;
  beat_t m_s1, m_s2;
  bit    armed = 1'b0;
  bit    last_acc = 1'b0;
  bit    bg = 1'b0;

  function automatic logic [95:0] model_beat(input logic [95:0] d, input bit bank, input bit byp);
    logic [95:0] o;
    o = d;
    if (!byp) begin
      for (int p = 0; p < 4; p++) begin
        o[24*p+16 +: 8] = m_tbl[bank][2][d[24*p+16 +: 8]];
        o[24*p+8  +: 8] = m_tbl[bank][1][d[24*p+8  +: 8]];
        o[24*p    +: 8] = m_tbl[bank][0][d[24*p    +: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [95:0] rep(input logic [23:0] p);
    return {p, p, p, p};
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model
  task automatic tick();
    bit ready, acc, apply;
    @(negedge I_clk);
    ready = O_tready || !m_s2.v;
    if (armed) begin
      chk("o_tvalid", {95'd0, O_tvalid}, {95'd0, m_s2.v});
      chk("o_tdata", O_tdata, m_s2.v ? m_s2.d : 96'd0);
      chk("o_tuser_tlast", {94'd0, O_tuser, O_tlast}, {94'd0, m_s2.v & m_s2.u, m_s2.v & m_s2.l});
      chk("i_tready", {95'd0, I_tready}, {95'd0, ready});
      chk("pend_byp_err", {93'd0, O_swap_pending, O_bypass, O_cfg_err}, {93'd0, m_pend, m_byp, m_err});
      if (O_tvalid && O_tready) n_out++;
    end
    acc = 1'b0;
    if (I_rst) begin
      m_act = 1'b0; m_pend = 1'b0; m_byp = 1'b1; m_err = 1'b0;
      m_s1 = '0; m_s2 = '0;
    end else begin
      acc   = I_tvalid && ready;
      apply = acc && I_tuser && m_pend;
      if (cfg_we) begin
        if (m_pend || cfg_swap) m_err = 1'b1;
        else begin
          for (int c = 0; c < 3; c++)
            if (cfg_addr[9:8] == 2'd3 || int'(cfg_addr[9:8]) == c)
              m_tbl[!m_act][c][cfg_addr[7:0]] = cfg_wdata;
        end
      end
      if (apply) begin
        m_act = !m_act; m_byp = 1'b0; m_pend = 1'b0;
      end else if (cfg_swap) begin
        m_pend = 1'b1;
      end
      if (ready) begin
        m_s2   = m_s1;
        m_s1.v = acc;
        m_s1.d = acc ? model_beat(I_tdata, m_act, m_byp) : 96'd0;
        m_s1.u = acc && I_tuser;
        m_s1.l = acc && I_tlast;
      end
    end
    last_acc = acc;
    @(posedge I_clk);
    #1;
  endtask

  task automatic set_idle();
    I_tvalid = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0; I_tdata = '0;
    cfg_we = 1'b0; cfg_swap = 1'b0; cfg_addr = '0; cfg_wdata = '0;
  endtask

  task automatic send(input logic [95:0] d, input bit u, input bit l);
    int guard;
    I_tvalid = 1'b1; I_tdata = d; I_tuser = u; I_tlast = l;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 100);
    if (!last_acc) chk("accept_timeout", 96'd0, 96'd1);
    I_tvalid = 1'b0; I_tuser = 1'b0; I_tlast = 1'b0;
  endtask

  task automatic cfg_wr(input logic [9:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    if (bg) begin
      I_tvalid = 1'($urandom_range(0, 1)); I_tdata = rand96();
      I_tuser = 1'b0; I_tlast = 1'($urandom_range(0, 1));
    end
    tick();
    cfg_we = 1'b0; I_tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    set_idle();
    O_tready = 1'b1;
    I_rst = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    I_rst = 1'b0;

    // Bypass after reset: identical beat two cycles after acceptance
    I_tvalid = 1'b1; I_tuser = 1'b1; I_tdata = 96'h123456_ABCDEF_001122_FFEE80;
    tick();
    set_idle();
    tick();
    chk("byp_data", O_tdata, 96'h123456_ABCDEF_001122_FFEE80);
    chk("byp_flags", {93'd0, O_tvalid, O_tuser, O_bypass}, 96'd7);
    for (int i = 0; i < 20; i++) begin
      I_tvalid = 1'($urandom_range(0, 1)); I_tdata = rand96(); I_tlast = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle();

    // Identity on all channels, then invert R, into the inactive bank
    for (int i = 0; i < 256; i++) cfg_wr({2'd3, 8'(i)}, 8'(i));
    for (int i = 0; i < 256; i++) cfg_wr({2'd2, 8'(i)}, 8'(255 - i));
    cfg_swap = 1'b1; tick(); cfg_swap = 1'b0;
    repeat (3) tick();
    chk("pend_before_sof", {95'd0, O_swap_pending}, 96'd1);
    I_tvalid = 1'b1; I_tuser = 1'b1; I_tdata = rep(24'h102030);
    tick();
    set_idle();
    chk("swap_applied", {94'd0, O_swap_pending, O_bypass}, 96'd0);
    tick();
    chk("r_invert", O_tdata, rep(24'hEF2030));
    for (int i = 0; i < 10; i++) send(rand96(), 1'b0, 1'($urandom_range(0, 1)));

    // Fill the other bank mid-frame under live traffic; current frame unaffected
    bg = 1'b1;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 256; i++) cfg_wr({2'(c), 8'(i)}, 8'($urandom));
    cfg_wr(10'h240, 8'h00);
    bg = 1'b0;
    repeat (3) tick();
    send(rep(24'h404040), 1'b0, 1'b0);
    tick();
    chk("iso_old_table", O_tdata, rep(24'hBF4040));
    cfg_swap = 1'b1; tick(); cfg_swap = 1'b0;
    send(rep(24'h400000), 1'b1, 1'b0);
    tick();
    chk("iso_new_table", {64'd0, O_tdata[95:88], O_tdata[71:64], O_tdata[47:40], O_tdata[23:16]}, 96'd0);

    // Write while pending is dropped and flagged
    cfg_wr(10'h205, 8'h77);
    cfg_swap = 1'b1; tick(); cfg_swap = 1'b0;
    cfg_wr(10'h205, 8'h00);
    chk("cfg_err", {95'd0, O_cfg_err}, 96'd1);
    send(rep(24'h050000), 1'b1, 1'b0);
    tick();
    chk("dropped_write", O_tdata, rep(24'h770000));

    // Swap request coinciding with a frame start stays pending
    I_tvalid = 1'b1; I_tuser = 1'b1; I_tdata = rand96(); cfg_swap = 1'b1;
    tick();
    set_idle();
    chk("swap_same_sof", {95'd0, O_swap_pending}, 96'd1);
    send(rand96(), 1'b1, 1'b0);
    repeat (3) tick();

    // Backpressure: 8 incrementing beats, 3-cycle stall mid-stream
    n0 = n_out;
    begin
      int bi;
      bi = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        O_tready = !(cyc >= 3 && cyc < 6);
        I_tvalid = (bi < 8);
        I_tdata  = 96'(bi + 1) * 96'h0101_0101_0101_0101_0101_0101 / 96'd1;
        I_tdata  = rep({8'(bi * 3 + 1), 8'(bi * 5 + 2), 8'(bi * 7 + 3)});
        tick();
        if (last_acc) bi++;
      end
    end
    set_idle();
    O_tready = 1'b1;
    chk("bp_beats_out", 96'(n_out - n0), 96'd8);

    // Random traffic with random backpressure, frame starts and swap requests
    for (int i = 0; i < 500; i++) begin
      if (!I_tvalid || last_acc) begin
        I_tvalid = ($urandom_range(0, 3) != 0);
        I_tdata  = rand96();
        I_tuser  = ($urandom_range(0, 15) == 0);
        I_tlast  = ($urandom_range(0, 7) == 0);
      end
      O_tready = ($urandom_range(0, 3) != 0);
      cfg_swap = ($urandom_range(0, 49) == 0);
      tick();
    end
    set_idle();
    O_tready = 1'b1;
    repeat (4) tick();

    // Reset with two beats stalled in flight
    O_tready = 1'b0;
    send(rand96(), 1'b1, 1'b0);
    send(rand96(), 1'b0, 1'b0);
    I_rst = 1'b1;
    tick();
    chk("rst_flush", {94'd0, O_tvalid, O_bypass}, 96'd1);
    I_rst = 1'b0;
    O_tready = 1'b1;
    n0 = n_out;
    repeat (5) tick();
    chk("rst_no_stale", 96'(n_out - n0), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
